// File: rtl/mask_serializer_core.sv
// Serializes one loaded mask row into OP_CHANNEL_WIDTH-bit column slices; lane i carries row bit i*step+c.
// Optional macro MASK_SERIALIZER_COL_IDX_EN adds the col_idx output (column currently on DOUT).
module mask_serializer_core #(
  parameter int IP_CHANNEL_WIDTH = 640,
  parameter int OP_CHANNEL_WIDTH = 20,
  parameter int STEP_SEL0        = 16,
  parameter int STEP_SEL1        = 32,
  parameter int STEP_SEL2        = 54,
  localparam int STEP_MAX01 = (STEP_SEL0 > STEP_SEL1) ? STEP_SEL0 : STEP_SEL1,
  localparam int STEP_MAX   = (STEP_MAX01 > STEP_SEL2) ? STEP_MAX01 : STEP_SEL2,
  localparam int COL_W      = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1,
  localparam int STEP_W     = $clog2(STEP_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IP_CHANNEL_WIDTH-1:0] DIN,
  input  logic                        load,
  input  logic                        next,
  input  logic [1:0]                  imageResolution,
  output logic                        done,
`ifdef MASK_SERIALIZER_COL_IDX_EN
  output logic [COL_W-1:0]            col_idx,
`endif
  output logic [OP_CHANNEL_WIDTH-1:0] DOUT
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                      state_q, state_d;
  logic [IP_CHANNEL_WIDTH-1:0] row_q, row_d;
  logic [STEP_W-1:0]           step_q, step_d;
  logic [COL_W-1:0]            col_q, col_d;
  logic                        done_q, done_d;
  logic [OP_CHANNEL_WIDTH-1:0] dout_q, dout_d;
  logic [STEP_W-1:0]           last_col;

  function automatic logic [STEP_W-1:0] step_of(input logic [1:0] res);
    case (res)
      2'b00:   return STEP_W'(STEP_SEL0);
      2'b10:   return STEP_W'(STEP_SEL2);
      default: return STEP_W'(STEP_SEL1);
    endcase
  endfunction

  // Right shift past the row width naturally yields 0 for out-of-range lanes.
  function automatic logic [OP_CHANNEL_WIDTH-1:0] column_of(
    input logic [IP_CHANNEL_WIDTH-1:0] row,
    input logic [STEP_W-1:0]           step,
    input logic [COL_W-1:0]            col
  );
    logic [OP_CHANNEL_WIDTH-1:0] r;
    logic [IP_CHANNEL_WIDTH-1:0] sh;
    r = '0;
    for (int i = 0; i < OP_CHANNEL_WIDTH; i++) begin
      sh   = row >> (i * int'(step) + int'(col));
      r[i] = sh[0];
    end
    return r;
  endfunction

  assign last_col = step_q - STEP_W'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    step_d  = step_q;
    col_d   = col_q;
    done_d  = done_q;
    dout_d  = dout_q;
    if (load) begin
      state_d = ACTIVE;
      row_d   = DIN;
      step_d  = step_of(imageResolution);
      col_d   = '0;
      done_d  = (step_d == STEP_W'(1));
      dout_d  = column_of(DIN, step_d, '0);
    end else if (next && (state_q == ACTIVE) && (STEP_W'(col_q) < last_col)) begin
      col_d  = col_q + COL_W'(1);
      done_d = (STEP_W'(col_d) == last_col);
      dout_d = column_of(row_q, step_q, col_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      step_q  <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      step_q  <= step_d;
      col_q   <= col_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign DOUT = dout_q;
  assign done = done_q;
`ifdef MASK_SERIALIZER_COL_IDX_EN
  assign col_idx = col_q;
`endif

endmodule

// File: tb/tb_mask_serializer_core.sv
// Randomized bench for mask_serializer_core: a column-list reference model feeds an expected queue checked by a monitor.
module tb_mask_serializer_core;
  localparam int IP = 640;
  localparam int OP = 20;
  localparam int IW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, load, next, done;
  logic [IP-1:0] din;
  logic [1:0]    res;
  logic [OP-1:0] dout;
`ifdef MASK_SERIALIZER_COL_IDX_EN
  logic [5:0]    col_idx;
`endif

  mask_serializer_core dut (
    .clk(clk),
    .rst_n(rst_n),
    .DIN(din),
    .load(load),
    .next(next),
    .imageResolution(res),
    .done(done),
`ifdef MASK_SERIALIZER_COL_IDX_EN
    .col_idx(col_idx),
`endif
    .DOUT(dout)
  );

  logic [OP:0]   exp_q[$];
  logic [OP-1:0] act_hist[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: on load the whole list of columns is precomputed.
  logic [OP-1:0] m_cols[$];
  int            m_step = 0;
  int            m_ptr = 0;
  bit            m_live = 0;
  bit            m_done = 0;
  logic [OP-1:0] m_cur = '0;

  function automatic int step_of(input logic [1:0] r);
    case (r)
      2'b00:   return 16;
      2'b01:   return 32;
      2'b10:   return 54;
      default: return 32;
    endcase
  endfunction

  function automatic logic [OP-1:0] ref_col(input logic [IP-1:0] d, input int step, input int c);
    logic [OP-1:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < OP; i++) begin
      idx = i * step + c;
      if (idx < IP) r[i] = d[IW'(idx)];
    end
    return r;
  endfunction

  function automatic logic [IP-1:0] rand_row();
    logic [IP-1:0] r;
    for (int k = 0; k < IP / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin
    logic [OP:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      act_hist.push_back(dout);
      if ({done, dout} !== e) begin
        miscompares++;
        $display("FAIL out_check t=%0t got done=%b dout=%h exp done=%b dout=%h",
                 $time, done, dout, e[OP], e[OP-1:0]);
      end
    end
  end

  task automatic cyc(input bit r, input bit ld, input bit nx, input logic [IP-1:0] d, input logic [1:0] rs);
    rst_n = r; load = ld; next = nx; din = d; res = rs;
    @(posedge clk);
    if (r) begin
      m_live = 0; m_done = 0; m_cur = '0; m_ptr = 0; m_step = 0;
    end else if (ld) begin
      m_step = step_of(rs);
      m_cols.delete();
      for (int c = 0; c < m_step; c++) m_cols.push_back(ref_col(d, m_step, c));
      m_ptr = 0; m_live = 1; m_cur = m_cols[0]; m_done = (m_step == 1);
    end else if (nx && m_live && m_ptr < m_step - 1) begin
      m_ptr++;
      m_cur  = m_cols[m_ptr];
      m_done = (m_ptr == m_step - 1);
    end
    exp_q.push_back({m_done, m_cur});
    #1;
  endtask

  task automatic run_row(input logic [IP-1:0] d, input logic [1:0] rs, input int nexts);
    cyc(0, 1, 0, d, rs);
    repeat (nexts) cyc(0, 0, 1, rand_row(), $urandom_range(0, 3));
  endtask

  initial begin
    logic [IP-1:0] d;
    logic [IP-1:0] rebuilt;

    rst_n = 1; load = 1; next = 1; din = '0; res = 2'b01;
    repeat (2) cyc(1, 1, 1, rand_row(), 2'b01);
    repeat (2) cyc(0, 0, 1, rand_row(), 2'b01);

    // Resolution 01 full row plus reassembly of all 32 columns.
    @(negedge clk); #1;
    act_hist.delete();
    d = rand_row();
    run_row(d, 2'b01, 31);
    @(negedge clk); #1;
    vectors++;
    rebuilt = '0;
    if (act_hist.size() == 32) begin
      for (int c = 0; c < 32; c++)
        for (int i = 0; i < OP; i++) rebuilt[IW'(i * 32 + c)] = act_hist[c][i];
    end
    if (rebuilt !== d) begin
      miscompares++;
      $display("FAIL reassembly cols=%0d got=%h exp=%h", act_hist.size(), rebuilt[63:0], d[63:0]);
    end

    // Hold after done, then load together with next.
    repeat (3) cyc(0, 0, 1, rand_row(), 2'b00);
    cyc(0, 1, 1, rand_row(), 2'b01);
    repeat (4) cyc(0, 0, 1, rand_row(), 2'b10);

    d = rand_row();
    run_row(d, 2'b00, 15);
    repeat (2) cyc(0, 0, 1, rand_row(), 2'b01);

    d = '1;
    run_row(d, 2'b10, 53);
    repeat (2) cyc(0, 0, 1, rand_row(), 2'b00);

    // Mid-row reload with the reserved resolution code.
    run_row(rand_row(), 2'b01, 10);
    run_row('0, 2'b11, 31);
    cyc(0, 0, 1, rand_row(), 2'b00);

    repeat (400)
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0), rand_row(), 2'($urandom_range(0, 3)));
    cyc(0, 0, 0, '0, 2'b00);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
